// File: rtl/clk_ce_seq.sv
// Lock-qualified reset sequencer plus fractional clock-enable strobes (68k phi1/phi2, Z80, pixel) on clk.
// Define CLK_CE_SEQ_STATS_EN to add saturating pulse counters on stat_cpu / stat_snd / stat_pix.
module clk_ce_seq #(
   parameter int CPU_NUM    = 1,
   parameter int CPU_DEN    = 5,
   parameter int SND_NUM    = 1,
   parameter int SND_DEN    = 20,
   parameter int PIX_NUM    = 3,
   parameter int PIX_DEN    = 40,
   parameter int ACC_W      = 8,
   parameter int RESET_HOLD = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pll_locked,
   input  logic        pause,
   output logic        sys_reset,
   output logic        ce_cpu_p1,
   output logic        ce_cpu_p2,
   output logic        ce_snd,
   output logic        ce_pix,
   output logic        running
`ifdef CLK_CE_SEQ_STATS_EN
   ,
   output logic [15:0] stat_cpu,
   output logic [15:0] stat_snd,
   output logic [15:0] stat_pix
`endif
);

   localparam int CNT_W = $clog2(RESET_HOLD + 1);
   localparam logic [ACC_W:0] CPU_N = (ACC_W + 1)'(CPU_NUM);
   localparam logic [ACC_W:0] CPU_D = (ACC_W + 1)'(CPU_DEN);
   localparam logic [ACC_W:0] SND_N = (ACC_W + 1)'(SND_NUM);
   localparam logic [ACC_W:0] SND_D = (ACC_W + 1)'(SND_DEN);
   localparam logic [ACC_W:0] PIX_N = (ACC_W + 1)'(PIX_NUM);
   localparam logic [ACC_W:0] PIX_D = (ACC_W + 1)'(PIX_DEN);

   typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;

   state_t             state, state_nxt;
   logic [1:0]         lock_sync;
   logic               lock_s;
   logic [CNT_W-1:0]   hold_cnt;
   logic               sys_reset_nxt, running_nxt;
   logic [ACC_W-1:0]   acc_cpu, acc_snd, acc_pix;
   logic [ACC_W:0]     cpu_step, snd_step, pix_step;
   logic               phase;

   // pll_locked is asynchronous to clk
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lock_sync <= 2'b00;
      else     lock_sync <= {lock_sync[0], pll_locked};
   end
   assign lock_s = lock_sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= WAIT_LOCK;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_LOCK: if (lock_s) state_nxt = HOLD;
         HOLD: begin
            if (!lock_s)                              state_nxt = WAIT_LOCK;
            else if (hold_cnt == CNT_W'(RESET_HOLD - 1)) state_nxt = RUN;
         end
         RUN:       if (!lock_s) state_nxt = WAIT_LOCK;
         default:   state_nxt = WAIT_LOCK;
      endcase
   end

   always_comb begin
      sys_reset_nxt = (state != RUN);
      running_nxt   = (state == RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sys_reset <= 1'b1;
         running   <= 1'b0;
      end else begin
         sys_reset <= sys_reset_nxt;
         running   <= running_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                hold_cnt <= '0;
      else if (state == HOLD) hold_cnt <= hold_cnt + 1'b1;
      else                    hold_cnt <= '0;
   end

   // Returns {pulse, next_acc}; sum < 2*DEN always fits in ACC_W bits.
   function automatic logic [ACC_W:0] ce_step(input logic [ACC_W-1:0] acc,
                                              input logic [ACC_W:0]   num,
                                              input logic [ACC_W:0]   den);
      logic [ACC_W:0] sum;
      sum = {1'b0, acc} + num;
      if (sum >= den) ce_step = {1'b1, ACC_W'(sum - den)};
      else            ce_step = {1'b0, sum[ACC_W-1:0]};
   endfunction

   assign cpu_step = ce_step(acc_cpu, CPU_N, CPU_D);
   assign snd_step = ce_step(acc_snd, SND_N, SND_D);
   assign pix_step = ce_step(acc_pix, PIX_N, PIX_D);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_cpu   <= '0;
         acc_snd   <= '0;
         acc_pix   <= '0;
         phase     <= 1'b0;
         ce_cpu_p1 <= 1'b0;
         ce_cpu_p2 <= 1'b0;
         ce_snd    <= 1'b0;
         ce_pix    <= 1'b0;
      end else if (state != RUN) begin
         acc_cpu   <= '0;
         acc_snd   <= '0;
         acc_pix   <= '0;
         phase     <= 1'b0;
         ce_cpu_p1 <= 1'b0;
         ce_cpu_p2 <= 1'b0;
         ce_snd    <= 1'b0;
         ce_pix    <= 1'b0;
      end else if (pause) begin
         ce_cpu_p1 <= 1'b0;
         ce_cpu_p2 <= 1'b0;
         ce_snd    <= 1'b0;
         ce_pix    <= 1'b0;
      end else begin
         acc_cpu   <= cpu_step[ACC_W-1:0];
         acc_snd   <= snd_step[ACC_W-1:0];
         acc_pix   <= pix_step[ACC_W-1:0];
         ce_cpu_p1 <= cpu_step[ACC_W] && !phase;
         ce_cpu_p2 <= cpu_step[ACC_W] && phase;
         ce_snd    <= snd_step[ACC_W];
         ce_pix    <= pix_step[ACC_W];
         if (cpu_step[ACC_W]) phase <= !phase;
      end
   end

`ifdef CLK_CE_SEQ_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_cpu <= '0;
         stat_snd <= '0;
         stat_pix <= '0;
      end else if (state != RUN) begin
         stat_cpu <= '0;
         stat_snd <= '0;
         stat_pix <= '0;
      end else begin
         if (ce_cpu_p1 && stat_cpu != 16'hFFFF) stat_cpu <= stat_cpu + 16'd1;
         if (ce_snd    && stat_snd != 16'hFFFF) stat_snd <= stat_snd + 16'd1;
         if (ce_pix    && stat_pix != 16'hFFFF) stat_pix <= stat_pix + 16'd1;
      end
   end
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      assert (CPU_NUM <= CPU_DEN && SND_NUM <= SND_DEN && PIX_NUM <= PIX_DEN)
         else $error("clk_ce_seq: a DEN is smaller than its NUM");
      assert (2 * CPU_DEN < (1 << ACC_W) && 2 * SND_DEN < (1 << ACC_W) && 2 * PIX_DEN < (1 << ACC_W))
         else $error("clk_ce_seq: ACC_W too narrow for a DEN");
   end
`endif

endmodule

// File: tb/tb_clk_ce_seq.sv
// Bench for clk_ce_seq: rate-based reference model checked every cycle, plus directed literal checks.
module tb_clk_ce_seq;
   localparam int RH = 1024;
   localparam int CN = 1, CD = 5, SN = 1, SD = 20, PN = 3, PD = 40;

   logic clk = 1'b0, rst = 1'b1, pll_locked = 1'b0, pause = 1'b0;
   logic sys_reset, ce_cpu_p1, ce_cpu_p2, ce_snd, ce_pix, running;
`ifdef CLK_CE_SEQ_STATS_EN
   logic [15:0] stat_cpu, stat_snd, stat_pix;
`endif

   int errors = 0;
   int checks = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   clk_ce_seq dut (
      .clk(clk), .rst(rst), .pll_locked(pll_locked), .pause(pause),
      .sys_reset(sys_reset), .ce_cpu_p1(ce_cpu_p1), .ce_cpu_p2(ce_cpu_p2),
      .ce_snd(ce_snd), .ce_pix(ce_pix), .running(running)
`ifdef CLK_CE_SEQ_STATS_EN
      , .stat_cpu(stat_cpu), .stat_snd(stat_snd), .stat_pix(stat_pix)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: RUN is visible three edges after the lock has been
   // seen high for RH+1 consecutive edges; the n-th active cycle pulses a
   // channel whenever floor(n*NUM/DEN) steps, odd-numbered CPU pulses are phi1.
   int lk = 0, lh0 = 0, lh1 = 0, lh2 = 0, n_act = 0;
   logic m_run = 1'b0, m_p1 = 1'b0, m_p2 = 1'b0, m_snd = 1'b0, m_pix = 1'b0;
   int m_st_cpu = 0, m_st_snd = 0, m_st_pix = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         lk = 0; lh0 = 0; lh1 = 0; lh2 = 0; n_act = 0;
         m_run = 1'b0; m_p1 = 1'b0; m_p2 = 1'b0; m_snd = 1'b0; m_pix = 1'b0;
         m_st_cpu = 0; m_st_snd = 0; m_st_pix = 0;
      end else begin
         m_run = (lh2 >= RH + 1);
         if (m_run) begin
            m_st_cpu = (m_st_cpu + int'(m_p1) > 65535) ? 65535 : m_st_cpu + int'(m_p1);
            m_st_snd = (m_st_snd + int'(m_snd) > 65535) ? 65535 : m_st_snd + int'(m_snd);
            m_st_pix = (m_st_pix + int'(m_pix) > 65535) ? 65535 : m_st_pix + int'(m_pix);
         end else begin
            m_st_cpu = 0; m_st_snd = 0; m_st_pix = 0;
         end
         if (m_run && !pause) begin
            n_act++;
            m_snd = (n_act * SN / SD) != ((n_act - 1) * SN / SD);
            m_pix = (n_act * PN / PD) != ((n_act - 1) * PN / PD);
            m_p1  = ((n_act * CN / CD) != ((n_act - 1) * CN / CD)) && ((n_act * CN / CD) % 2 == 1);
            m_p2  = ((n_act * CN / CD) != ((n_act - 1) * CN / CD)) && ((n_act * CN / CD) % 2 == 0);
         end else begin
            m_p1 = 1'b0; m_p2 = 1'b0; m_snd = 1'b0; m_pix = 1'b0;
            if (!m_run) n_act = 0;
         end
         lh2 = lh1;
         lh1 = lh0;
         lk  = pll_locked ? lk + 1 : 0;
         lh0 = lk;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cycle_outputs", {26'd0, sys_reset, running, ce_cpu_p1, ce_cpu_p2, ce_snd, ce_pix},
               {26'd0, !m_run, m_run, m_p1, m_p2, m_snd, m_pix});
`ifdef CLK_CE_SEQ_STATS_EN
         check("cycle_stats", {stat_cpu, stat_snd[7:0], stat_pix[7:0]},
               {m_st_cpu[15:0], m_st_snd[7:0], m_st_pix[7:0]});
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [3:0] strobes();
      return {ce_cpu_p1, ce_cpu_p2, ce_snd, ce_pix};
   endfunction

   // k = index of the edge (0 = first edge after the call) where sys_reset falls, -1 on timeout
   task automatic wait_fall(output int k);
      k = -1;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (!sys_reset) begin
            k = i;
            break;
         end
      end
   endtask

   logic [3:0] pat [0:159];
   int fall, c_p1, c_p2, c_snd, c_pix, mism, quiet, first_p1, first_p2, first_snd, first_pix, first_cpu;
   logic expect_p1, alt_ok;
   logic [1:0] first_cpu_v;

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      check("reset_state", {26'd0, sys_reset, running, strobes()}, 32'b100000);
      repeat (5) tick();
      check("no_lock_stays_reset", {31'd0, sys_reset}, 32'd1);

      // Bring-up
      pll_locked = 1'b1;
      wait_fall(fall);
      check("bringup_fall_edge", fall, 32'd1027);
      check("bringup_running", {31'd0, running}, 32'd1);
      for (int r = 0; r < 160; r++) begin
         pat[r] = strobes();
         tick();
      end

      c_p1 = 0; c_p2 = 0; c_snd = 0; c_pix = 0; alt_ok = 1'b1; expect_p1 = 1'b1;
      first_p1 = -1; first_p2 = -1; first_snd = -1; first_pix = -1;
      for (int r = 0; r < 80; r++) begin
         c_p1 += int'(pat[r][3]); c_p2 += int'(pat[r][2]);
         c_snd += int'(pat[r][1]); c_pix += int'(pat[r][0]);
         if (pat[r][3] && first_p1 < 0) first_p1 = r;
         if (pat[r][2] && first_p2 < 0) first_p2 = r;
         if (pat[r][1] && first_snd < 0) first_snd = r;
         if (pat[r][0] && first_pix < 0) first_pix = r;
         if (pat[r][3] && pat[r][2]) alt_ok = 1'b0;
         else if (pat[r][3]) begin if (!expect_p1) alt_ok = 1'b0; expect_p1 = 1'b0; end
         else if (pat[r][2]) begin if (expect_p1) alt_ok = 1'b0; expect_p1 = 1'b1; end
      end
      check("rate_p1", c_p1, 32'd8);
      check("rate_p2", c_p2, 32'd8);
      check("rate_snd", c_snd, 32'd4);
      check("rate_pix", c_pix, 32'd6);
      check("cpu_alternate", {31'd0, alt_ok}, 32'd1);
      check("first_p1_pos", first_p1, 32'd4);
      check("first_p2_pos", first_p2, 32'd9);
      check("first_snd_pos", first_snd, 32'd19);
      check("first_pix_pos", first_pix, 32'd13);
      mism = 0;
      for (int r = 0; r < 80; r++) mism += int'(pat[r] != pat[r + 80]);
      check("period_80_repeat", mism, 32'd0);

      // Lock loss at RUN cycle 200
      for (int r = 160; r < 200; r++) tick();
      pll_locked = 1'b0;
      repeat (4) tick();
      check("lockloss_outputs", {26'd0, sys_reset, running, strobes()}, 32'b100000);
      repeat (10) tick();

      // Re-lock, then pause 37 cycles at RUN cycle 100
      pll_locked = 1'b1;
      wait_fall(fall);
      check("relock_fall_edge", fall, 32'd1027);
      first_cpu = -1; first_cpu_v = 2'b00;
      for (int r = 0; r <= 100; r++) begin
         if (first_cpu < 0 && strobes()[3:2] != 2'b00) begin
            first_cpu = r;
            first_cpu_v = strobes()[3:2];
         end
         if (r < 100) tick();
      end
      check("relock_first_cpu_pos", first_cpu, 32'd4);
      check("relock_first_cpu_is_p1", {30'd0, first_cpu_v}, 32'b10);
      pause = 1'b1;
      quiet = 0;
      for (int i = 0; i < 37; i++) begin
         tick();
         quiet += int'(strobes() != 4'b0000);
      end
      pause = 1'b0;
      check("pause_no_strobes", quiet, 32'd0);
      mism = 0;
      for (int j = 0; j < 80; j++) begin
         tick();
         mism += int'(strobes() != pat[(138 + j - 37) % 80]);
      end
      check("pause_shift_37", mism, 32'd0);

      // Asynchronous reset between clock edges
      #3 rst = 1'b1;
      #1 check("async_reset", {26'd0, sys_reset, running, strobes()}, 32'b100000);
      @(negedge clk);
      rst = 1'b0;
      wait_fall(fall);
      check("restart_fall_edge", fall, 32'd1027);
      for (int r = 0; r < 800; r++) tick();
`ifdef CLK_CE_SEQ_STATS_EN
      check("stat_cpu_800", {16'd0, stat_cpu}, 32'd80);
      check("stat_snd_800", {16'd0, stat_snd}, 32'd40);
      check("stat_pix_800", {16'd0, stat_pix}, 32'd60);
`endif
      pll_locked = 1'b0;
      repeat (5) tick();
      check("final_lockloss", {26'd0, sys_reset, running, strobes()}, 32'b100000);
`ifdef CLK_CE_SEQ_STATS_EN
      check("stats_cleared", {stat_cpu, stat_snd | stat_pix}, 32'd0);
`endif
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clk_ce_seq.md
Name: clk_ce_seq

Overview:
- Sits directly downstream of the system PLL. Consumes the 80 MHz system clock and the PLL `locked` flag.
- Produces a clean, lock-qualified system reset plus fractional clock-enable strobes for the core:
  - 68000 phi1/phi2 enables at 8 MHz.
  - Z80 enable at 4 MHz.
  - Pixel enable at 6 MHz.
- All core logic runs on `clk` and is gated by these strobes. No derived clocks exist downstream.

Parameters:
- CPU_NUM, 1, numerator of 68k phase-enable rate (phase rate = clk*CPU_NUM/CPU_DEN; 80 MHz*1/5 = 16 MHz phases = 8 MHz CPU)
- CPU_DEN, 5, denominator of 68k phase-enable rate
- SND_NUM, 1, numerator of Z80 enable rate
- SND_DEN, 20, denominator of Z80 enable rate (4 MHz)
- PIX_NUM, 3, numerator of pixel enable rate
- PIX_DEN, 40, denominator of pixel enable rate (6 MHz)
- ACC_W, 8, accumulator width; must satisfy 2*DEN < 2^ACC_W for every DEN
- RESET_HOLD, 1024, cycles sys_reset stays high after lock is stable

Ports:
- clk  in  1  80 MHz system clock (PLL outclk_0)
- rst  in  1  asynchronous active-high reset
- pll_locked  in  1  PLL lock flag, asynchronous to clk
- pause  in  1  freezes all enables, synchronous
- sys_reset  out  1  core reset, active-high, deasserts synchronously
- ce_cpu_p1  out  1  68k phi1 enable, one-cycle pulse
- ce_cpu_p2  out  1  68k phi2 enable, one-cycle pulse
- ce_snd  out  1  Z80 enable, one-cycle pulse
- ce_pix  out  1  pixel enable, one-cycle pulse
- running  out  1  high while FSM is in RUN

Behaviour:
- Reset values on rst (async): sys_reset=1, all ce_*=0, running=0, FSM=WAIT_LOCK, hold counter=0, all accumulators=0, phase toggle=0 (next CPU pulse is p1), lock synchroniser=00.
- Lock synchroniser: pll_locked passes through a 2-flop synchroniser into lock_s.
- FSM states:
  - WAIT_LOCK: sys_reset=1. Go to HOLD on the first edge where lock_s=1, with counter cleared.
  - HOLD: sys_reset=1, counter increments each cycle. When counter==RESET_HOLD-1, go to RUN.
  - RUN: sys_reset=0, running=1.
- Reset timing: sys_reset and running are registered from the FSM state. sys_reset falls exactly RESET_HOLD+3 clk edges after the first edge at which pll_locked is sampled high.
- Loss of lock: lock_s=0 in HOLD or RUN forces WAIT_LOCK on the next edge. sys_reset rises one cycle later. Accumulators and phase toggle are cleared while not in RUN.
- Enable generation (per channel, RUN state and pause=0 only):
  - Each cycle, sum = acc + NUM, computed at ACC_W+1 bits.
  - If sum >= DEN: acc <= sum - DEN and the strobe is 1 this cycle (registered, so it appears on the next edge); otherwise acc <= sum.
  - Long-run rate is exactly NUM/DEN. At most one pulse per cycle per channel.
- CPU phases: each CPU-channel pulse is routed to ce_cpu_p1 or ce_cpu_p2 by the phase toggle, starting with p1. The toggle flips after each pulse. p1 and p2 are never high in the same cycle.
- Strobes outside RUN: every strobe is 0 whenever sys_reset=1.
- Pause: with pause=1, accumulators and phase toggle hold and all ce_*=0. On pause release, the sequence resumes exactly where it stopped. pause does not affect the FSM or sys_reset.
- Simultaneous events:
  - rst overrides everything.
  - Lock loss during pause still resets the sequence.
- Parameter check: a DEN < NUM is a configuration error, flagged by a simulation-only assertion.

Optional Feature:
- Macro: CLK_CE_SEQ_STATS_EN.
- When defined:
  - Adds 16-bit saturating counters of ce_cpu_p1, ce_snd and ce_pix pulses since entering RUN.
  - Exposed on output stat_cpu, stat_snd, stat_pix (16 bits each).
  - Counters clear on rst and whenever the FSM is not in RUN.
  - Counters saturate at 16'hFFFF.
- When undefined: those ports and counters do not exist, and the enable behaviour is identical.

Test Plan:
- Lock bring-up: rst pulse, then pll_locked=1 at edge 0 with RESET_HOLD=1024 -> sys_reset=1 through edge 1026, falls at edge 1027; running rises on the same edge.
- Rates: first 80 RUN cycles, pause=0 -> 8 ce_cpu_p1, 8 ce_cpu_p2 strictly alternating with p1 first, 4 ce_snd, 6 ce_pix. Repeats identically every 80 cycles.
- Lock loss: drop pll_locked in RUN at cycle 200 -> sys_reset=1 and all ce_*=0 within 4 cycles. Re-lock -> full RESET_HOLD sequence repeats, and the first CPU pulse after RUN is p1.
- Pause: assert pause for 37 cycles mid-run -> zero strobes during pause. Pulse positions after release are shifted by exactly 37 cycles versus an unpaused run.
- Async reset mid-run: rst pulse not aligned to clk -> all outputs take reset values immediately. Sequence restarts from WAIT_LOCK.
- CLK_CE_SEQ_STATS_EN: run 800 RUN cycles -> stat_cpu=80, stat_snd=40, stat_pix=60. After lock loss, all stats=0.
